rpn_operand_sequencer: RTL and testbench

- Upstream control stage of the 16-bit calculator datapath. Collects operand A, operand B and a 5-bit operator code from the switch bus using single-cycle enter pulses.
- Holds A, B and the operator code stable as registered inputs to the combinational ALU.
- Captures the ALU result into a register and supports RPN-style chaining: the result becomes the next A.
- Rejects operator codes the ALU does not implement, and supports a one-step undo.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/rpn_operand_sequencer.sv | 121 ++++++++++++
 tb/tb_rpn_operand_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: sequencer states,
// operator codes understood by the ALU, and the legality test for them.
package calc_pkg;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam logic [4:0] OP_ADD = 5'b1_0000;
  localparam logic [4:0] OP_MUL = 5'b1_0001;
  localparam logic [4:0] OP_OR  = 5'b1_0010;
  localparam logic [4:0] OP_SUB = 5'b1_0100;
  localparam logic [4:0] OP_AND = 5'b1_0101;

  function automatic logic is_legal_op(input logic [4:0] code);
    case (code)
      OP_ADD, OP_MUL, OP_OR, OP_SUB, OP_AND: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rpn_operand_sequencer.sv
// Operand/operator collection FSM and register bank feeding the combinational
// ALU; captures the ALU result and chains it back as the next operand A.
//
// state   | meaning
// WAIT_A  | waiting for operand A on enter
// WAIT_B  | waiting for operand B on enter
// WAIT_OP | waiting for a legal operator code on enter
// SHOW    | operands held; result captured on first cycle, enter chains
module rpn_operand_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int OP_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                enter,
  input  logic                undo,
  input  logic [WIDTH-1:0]    alu_result,
  output logic [WIDTH-1:0]    A,
  output logic [WIDTH-1:0]    B,
  output logic [OP_WIDTH-1:0] operador,
  output logic [WIDTH-1:0]    result,
  output logic                result_valid,
  output logic                op_error,
  output logic [1:0]          state_o
);

  state_t state_q, state_d;
  logic load_a, load_b, load_op, capture, chain, drop_valid, illegal;
  logic [OP_WIDTH-1:0] code;

  assign code    = data_in[OP_WIDTH-1:0];
  assign state_o = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= WAIT_A;
    else       state_q <= state_d;
  end

  // Undo takes priority over enter in every state.
  always_comb begin
    state_d    = state_q;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    capture    = 1'b0;
    chain      = 1'b0;
    drop_valid = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (enter && !undo) begin
          load_a  = 1'b1;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (undo) state_d = WAIT_A;
        else if (enter) begin
          load_b  = 1'b1;
          state_d = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (undo) state_d = WAIT_B;
        else if (enter) begin
          if (is_legal_op(code)) begin
            load_op = 1'b1;
            state_d = SHOW;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      SHOW: begin
        if (undo) begin
          drop_valid = 1'b1;
          state_d    = WAIT_OP;
        end else begin
          capture = !result_valid;
          if (enter && result_valid) begin
            chain      = 1'b1;
            drop_valid = 1'b1;
            state_d    = WAIT_B;
          end
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A            <= '0;
      B            <= '0;
      operador     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      op_error     <= 1'b0;
    end else begin
      op_error <= illegal;
      if (load_a) A <= data_in;
      if (load_b) B <= data_in;
      if (load_op) operador <= code;
      if (chain) begin
        A        <= result;
        B        <= '0;
        operador <= '0;
      end
      if (capture) begin
        result       <= alu_result;
        result_valid <= 1'b1;
      end else if (drop_valid) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rpn_operand_sequencer.sv
// Directed bench for rpn_operand_sequencer with a behavioural ALU model
// closing the loop from A/B/operador back to alu_result.
module tb_rpn_operand_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = '0;
  logic        enter = 1'b0;
  logic        undo = 1'b0;
  logic [15:0] alu_result;
  logic [15:0] A, B, result;
  logic [4:0]  operador;
  logic        result_valid, op_error;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rpn_operand_sequencer #(.WIDTH(16), .OP_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enter(enter), .undo(undo),
    .alu_result(alu_result), .A(A), .B(B), .operador(operador),
    .result(result), .result_valid(result_valid), .op_error(op_error),
    .state_o(state_o)
  );

  always_comb begin
    case (operador)
      OP_ADD:  alu_result = A + B;
      OP_MUL:  alu_result = A * B;
      OP_OR:   alu_result = A | B;
      OP_SUB:  alu_result = A - B;
      OP_AND:  alu_result = A & B;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic press(input logic [15:0] val);
    @(negedge clk) begin data_in = val; enter = 1'b1; end
    @(negedge clk) enter = 1'b0;
  endtask

  task automatic press_undo();
    @(negedge clk) undo = 1'b1;
    @(negedge clk) undo = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_state", state_o, 0);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_op", operador, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_err", op_error, 0);

    // ADD 3+5
    press(16'd3);
    check("add_st1", state_o, 1);
    check("add_A", A, 3);
    press(16'd5);
    check("add_st2", state_o, 2);
    check("add_B", B, 5);
    press(16'h0010);
    check("add_st3", state_o, 3);
    check("add_op", operador, 5'h10);
    check("add_valid_early", result_valid, 0);
    @(negedge clk);
    check("add_valid", result_valid, 1);
    check("add_result", result, 8);
    // chain
    press(16'h0000);
    check("chain_st", state_o, 1);
    check("chain_A", A, 8);
    check("chain_B", B, 0);
    check("chain_op", operador, 0);
    check("chain_valid", result_valid, 0);
    check("chain_result", result, 8);

    // SUB 3-5 wraps
    do_reset();
    press(16'd3);
    press(16'd5);
    press(16'h0014);
    @(negedge clk);
    check("sub_result", result, 16'hFFFE);
    check("sub_valid", result_valid, 1);
    press(16'h0000);
    check("sub_chain_A", A, 16'hFFFE);
    check("sub_chain_st", state_o, 1);
    check("sub_chain_valid", result_valid, 0);

    // MUL 300*300, with enter held into the first SHOW cycle (ignored)
    do_reset();
    press(16'd300);
    press(16'd300);
    @(negedge clk) begin data_in = 16'h0011; enter = 1'b1; end
    @(negedge clk);
    check("mul_st_show", state_o, 3);
    @(negedge clk) enter = 1'b0;
    check("mul_st_held", state_o, 3);
    check("mul_valid", result_valid, 1);
    check("mul_result", result, 16'h5F90);
    check("mul_A_kept", A, 16'd300);

    // illegal opcode then AND
    do_reset();
    press(16'hF0F0);
    press(16'h0FF0);
    press(16'h0007);
    check("ill_err", op_error, 1);
    check("ill_st", state_o, 2);
    check("ill_op", operador, 0);
    @(negedge clk);
    check("ill_err_clear", op_error, 0);
    press(16'h0015);
    check("and_st", state_o, 3);
    @(negedge clk);
    check("and_result", result, 16'h00F0);
    check("and_valid", result_valid, 1);

    // undo in SHOW
    press_undo();
    check("undo_show_st", state_o, 2);
    check("undo_show_valid", result_valid, 0);
    check("undo_show_result", result, 16'h00F0);
    // enter + undo together in WAIT_OP: undo wins
    @(negedge clk) begin data_in = 16'h1234; enter = 1'b1; undo = 1'b1; end
    @(negedge clk) begin enter = 1'b0; undo = 1'b0; end
    check("both_st", state_o, 1);
    check("both_B", B, 16'h0FF0);
    check("both_op", operador, 5'h15);
    press_undo();
    check("undo_b_st", state_o, 0);
    press_undo();
    check("undo_a_st", state_o, 0);
    check("undo_a_A", A, 16'hF0F0);

    // asynchronous reset in SHOW
    press(16'd7);
    press(16'd2);
    press(16'h0012);
    @(negedge clk);
    check("pre_ar_valid", result_valid, 1);
    check("pre_ar_result", result, 16'd7);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("ar_state", state_o, 0);
    check("ar_A", A, 0);
    check("ar_B", B, 0);
    check("ar_op", operador, 0);
    check("ar_result", result, 0);
    check("ar_valid", result_valid, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("post_ar_state", state_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
